// File: rtl/memory_pipe.sv
// rtl/memory_pipe.sv - Y86-64 memory stage: E->M pipeline register plus byte-addressed data memory
module memory_pipe #(
  parameter int DMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_bubble,
  input  logic [3:0]  e_stat,
  input  logic [3:0]  e_icode,
  input  logic        e_Cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  output logic [3:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_Cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [63:0] m_valM,
  output logic [3:0]  m_stat
);

  localparam int AW = $clog2(DMEM_BYTES);

  localparam logic [3:0] STAT_AOK = 4'b1000;
  localparam logic [3:0] STAT_ADR = 4'b0010;
  localparam logic [3:0] ICODE_NOP = 4'h1;
  localparam logic [3:0] REG_NONE = 4'hF;

  // Highest base address whose full 8-byte word still fits in memory.
  localparam logic [63:0] LAST_WORD_ADDR = 64'(DMEM_BYTES - 8);

  logic [7:0]    mem [DMEM_BYTES];
  logic [63:0]   memAddr;
  logic          memRead;
  logic          memWrite;
  logic          memAccess;
  logic          addrOk;
  logic          writeEn;
  logic [AW-1:0] baseIdx;

  // E->M pipeline register; reset wins over bubble, no stall so it loads every cycle.
  always_ff @(posedge clk) begin
    if (reset || M_bubble) begin
      M_stat  <= STAT_AOK;
      M_icode <= ICODE_NOP;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= REG_NONE;
      M_dstM  <= REG_NONE;
    end else begin
      M_stat  <= e_stat;
      M_icode <= e_icode;
      M_Cnd   <= e_Cnd;
      M_valE  <= e_valE;
      M_valA  <= e_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= e_dstM;
    end
  end

  // Decode the access kind and address source from the instruction sitting in M.
  always_comb begin
    memAddr  = '0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    case (M_icode)
      4'h4, 4'h8, 4'hA: begin
        memAddr  = M_valE;
        memWrite = 1'b1;
      end
      4'h5: begin
        memAddr = M_valE;
        memRead = 1'b1;
      end
      4'h9, 4'hB: begin
        memAddr = M_valA;
        memRead = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign memAccess = memRead | memWrite;
  // Full 64-bit unsigned compare so huge addresses never alias into range.
  assign addrOk    = (memAddr <= LAST_WORD_ADDR);
  assign baseIdx   = memAddr[AW-1:0];
  assign writeEn   = memWrite && addrOk && (M_stat == STAT_AOK);

  // Little-endian combinational read; zero when nothing valid is being read.
  always_comb begin
    m_valM = '0;
    if (memRead && addrOk) begin
      for (int i = 0; i < 8; i++) begin
        m_valM[8*i +: 8] = mem[baseIdx + AW'(i)];
      end
    end
  end

  // Faulting status only replaces AOK; an earlier fault keeps its own code.
  always_comb begin
    m_stat = M_stat;
    if (memAccess && !addrOk && (M_stat == STAT_AOK)) begin
      m_stat = STAT_ADR;
    end
  end

  // Data memory: reset clears every byte; otherwise the store in M commits at the edge ending its cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DMEM_BYTES; i++) begin
        mem[i] <= '0;
      end
    end else if (writeEn) begin
      for (int i = 0; i < 8; i++) begin
        mem[baseIdx + AW'(i)] <= M_valA[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_memory_pipe.sv
// tb/tb_memory_pipe.sv - randomized and directed checks of memory_pipe against a behavioural model
module tb_memory_pipe;

  localparam int DMEM_BYTES = 1024;
  localparam logic [3:0] AOK = 4'b1000;
  localparam logic [3:0] HLT = 4'b0100;
  localparam logic [3:0] ADR = 4'b0010;
  localparam logic [3:0] INS = 4'b0001;

  logic        clk = 1'b0;
  logic        reset;
  logic        M_bubble;
  logic [3:0]  e_stat;
  logic [3:0]  e_icode;
  logic        e_Cnd;
  logic [63:0] e_valE;
  logic [63:0] e_valA;
  logic [3:0]  e_dstE;
  logic [3:0]  e_dstM;
  logic [3:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic [63:0] m_valM;
  logic [3:0]  m_stat;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  memory_pipe #(.DMEM_BYTES(DMEM_BYTES)) dut (
    .clk(clk), .reset(reset), .M_bubble(M_bubble),
    .e_stat(e_stat), .e_icode(e_icode), .e_Cnd(e_Cnd),
    .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM),
    .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .m_valM(m_valM), .m_stat(m_stat)
  );

  typedef struct {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } instr_t;

  instr_t     inM;
  logic [7:0] bytes [DMEM_BYTES];
  bit         modelLive = 0;

  function automatic instr_t bubbleInstr();
    instr_t b;
    b.stat = AOK; b.icode = 4'h1; b.cnd = 1'b0;
    b.valE = 64'd0; b.valA = 64'd0; b.dstE = 4'hF; b.dstM = 4'hF;
    return b;
  endfunction

  function automatic bit isLoad(input logic [3:0] ic);
    return ic == 4'd5 || ic == 4'd9 || ic == 4'd11;
  endfunction

  function automatic bit isStore(input logic [3:0] ic);
    return ic == 4'd4 || ic == 4'd8 || ic == 4'd10;
  endfunction

  function automatic logic [63:0] addrOf(input instr_t r);
    return (r.icode == 4'd9 || r.icode == 4'd11) ? r.valA : r.valE;
  endfunction

  // The whole 8-byte word must lie inside memory.
  function automatic bit wordFits(input logic [63:0] a);
    return (a < 64'(DMEM_BYTES)) && (64'(DMEM_BYTES) - a >= 64'd8);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Model update at each edge: store in M commits unless reset, then M reloads.
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DMEM_BYTES; k++) bytes[k] = 8'h00;
      inM = bubbleInstr();
      modelLive = 1;
    end else if (modelLive) begin
      if (isStore(inM.icode) && inM.stat == AOK && wordFits(addrOf(inM))) begin
        for (int k = 0; k < 8; k++) bytes[int'(addrOf(inM)) + k] = inM.valA[8*k +: 8];
      end
      if (M_bubble) inM = bubbleInstr();
      else begin
        inM.stat = e_stat; inM.icode = e_icode; inM.cnd = e_Cnd;
        inM.valE = e_valE; inM.valA = e_valA; inM.dstE = e_dstE; inM.dstM = e_dstM;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (modelLive) begin
      logic [63:0] a;
      logic [63:0] expValM;
      logic [3:0]  expStat;
      a = addrOf(inM);
      expValM = 64'd0;
      if (isLoad(inM.icode) && wordFits(a)) begin
        for (int k = 0; k < 8; k++) expValM = expValM | (64'(bytes[int'(a) + k]) << (8 * k));
      end
      expStat = inM.stat;
      if ((isLoad(inM.icode) || isStore(inM.icode)) && !wordFits(a) && inM.stat == AOK) expStat = ADR;
      chk("M_stat", 64'(M_stat), 64'(inM.stat));
      chk("M_icode", 64'(M_icode), 64'(inM.icode));
      chk("M_Cnd", 64'(M_Cnd), 64'(inM.cnd));
      chk("M_valE", M_valE, inM.valE);
      chk("M_valA", M_valA, inM.valA);
      chk("M_dstE", 64'(M_dstE), 64'(inM.dstE));
      chk("M_dstM", 64'(M_dstM), 64'(inM.dstM));
      chk("m_valM", m_valM, expValM);
      chk("m_stat", 64'(m_stat), 64'(expStat));
    end
  end

  task automatic step(input logic rst, input logic bub, input logic [3:0] st, input logic [3:0] ic,
                      input logic cnd, input logic [63:0] vE, input logic [63:0] vA,
                      input logic [3:0] dE, input logic [3:0] dM);
    reset = rst; M_bubble = bub; e_stat = st; e_icode = ic; e_Cnd = cnd;
    e_valE = vE; e_valA = vA; e_dstE = dE; e_dstM = dM;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] randAddr();
    case ($urandom_range(0, 7))
      0, 1, 2: return 64'($urandom_range(0, 15) * 8);
      3:       return 64'($urandom_range(0, DMEM_BYTES - 8));
      4:       return 64'($urandom_range(DMEM_BYTES - 12, DMEM_BYTES + 4));
      5:       return 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
      6:       return {32'($urandom), 32'($urandom)};
      default: return 64'($urandom_range(0, 127));
    endcase
  endfunction

  initial begin
    logic [3:0] icList [12];
    logic [3:0] stList [4];
    icList = '{4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11, 4'd4, 4'd5, 4'd6, 4'd0, 4'd1, 4'd7};
    stList = '{AOK, HLT, ADR, INS};

    // Reset with an OPq in flight.
    step(1, 0, AOK, 4'd6, 1, 64'd5, 64'd6, 4'd1, 4'd2);
    chk("rst M_icode", 64'(M_icode), 64'd1);
    chk("rst M_stat", 64'(M_stat), 64'(4'b1000));
    chk("rst M_dstE", 64'(M_dstE), 64'hF);
    chk("rst M_dstM", 64'(M_dstM), 64'hF);
    chk("rst m_valM", m_valM, 64'd0);
    chk("rst m_stat", 64'(m_stat), 64'(4'b1000));

    // Store then load of the same word.
    step(0, 0, AOK, 4'd4, 0, 64'd16, 64'h1122334455667788, 4'hF, 4'hF);
    chk("rmmovq m_stat", 64'(m_stat), 64'(AOK));
    step(0, 0, AOK, 4'd5, 0, 64'd16, 64'd0, 4'hF, 4'd3);
    chk("mrmovq m_valM", m_valM, 64'h1122334455667788);
    chk("mrmovq low byte", 64'(m_valM[7:0]), 64'h88);
    chk("mrmovq M_dstM", 64'(M_dstM), 64'd3);

    // ALU passthrough.
    step(0, 0, AOK, 4'd6, 1, 64'd10, 64'd0, 4'd2, 4'hF);
    chk("pass M_icode", 64'(M_icode), 64'd6);
    chk("pass M_valE", M_valE, 64'd10);
    chk("pass M_dstE", 64'(M_dstE), 64'd2);
    chk("pass M_Cnd", 64'(M_Cnd), 64'd1);
    chk("pass m_stat", 64'(m_stat), 64'(AOK));

    // Straddling store faults and leaves memory alone; last valid word is usable.
    step(0, 0, AOK, 4'd4, 0, 64'(DMEM_BYTES - 4), 64'hDEADBEEFDEADBEEF, 4'hF, 4'hF);
    chk("adr store m_stat", 64'(m_stat), 64'(4'b0010));
    step(0, 0, AOK, 4'd5, 0, 64'(DMEM_BYTES - 8), 64'd0, 4'hF, 4'd4);
    chk("edge load m_valM", m_valM, 64'd0);
    chk("edge load m_stat", 64'(m_stat), 64'(AOK));
    step(0, 0, AOK, 4'd11, 0, 64'd0, 64'hFFFFFFFFFFFFFFF8, 4'd4, 4'd5);
    chk("adr popq m_stat", 64'(m_stat), 64'(4'b0010));
    chk("adr popq m_valM", m_valM, 64'd0);

    // Bubble over a pushq while an earlier pushq in M still commits.
    step(0, 0, AOK, 4'd10, 0, 64'd40, 64'h000000000000CAFE, 4'd4, 4'hF);
    step(0, 1, AOK, 4'd10, 0, 64'd48, 64'h000000000000BEEF, 4'd4, 4'hF);
    chk("bubble M_icode", 64'(M_icode), 64'd1);
    chk("bubble M_dstE", 64'(M_dstE), 64'hF);
    step(0, 0, AOK, 4'd5, 0, 64'd40, 64'd0, 4'hF, 4'd1);
    chk("pushq committed", m_valM, 64'h000000000000CAFE);
    step(0, 0, AOK, 4'd5, 0, 64'd48, 64'd0, 4'hF, 4'd1);
    chk("bubbled pushq absent", m_valM, 64'd0);

    // Non-AOK status suppresses the write and passes through.
    step(0, 0, HLT, 4'd8, 0, 64'd32, 64'h7777777777777777, 4'd4, 4'hF);
    chk("hlt m_stat", 64'(m_stat), 64'(4'b0100));
    step(0, 0, AOK, 4'd5, 0, 64'd32, 64'd0, 4'hF, 4'd1);
    chk("hlt no write", m_valM, 64'd0);

    // Randomized traffic checked by the negedge compare process.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0]  ic;
      logic [63:0] vE;
      logic [63:0] vA;
      ic = icList[$urandom_range(0, 11)];
      vE = randAddr();
      vA = (ic == 4'd9 || ic == 4'd11) ? randAddr() : {32'($urandom), 32'($urandom)};
      step($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
           ($urandom_range(0, 5) == 0) ? stList[$urandom_range(0, 3)] : AOK,
           ic, 1'($urandom), vE, vA, 4'($urandom), 4'($urandom));
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
